// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with almost-full/almost-empty thresholds and sticky overflow/underflow flags
module sync_fifo #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int CNT_W     = 5,
    parameter int AF_THRESH = 14,
    parameter int AE_THRESH = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] data_in,
    input  logic              clr_err,
    output logic [DATA_W-1:0] data_out,
    output logic [CNT_W-1:0]  count,
    output logic              fifo_full,
    output logic              fifo_empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              overflow,
    output logic              underflow
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              wr_ok;
    logic              rd_ok;

    // Status flags decode only the count register, so push/pop never reach them combinationally.
    always_comb begin
        fifo_full    = count == CNT_W'(DEPTH);
        fifo_empty   = count == '0;
        almost_full  = count >= CNT_W'(AF_THRESH);
        almost_empty = count <= CNT_W'(AE_THRESH);
        wr_ok        = push & (!fifo_full | pop);
        rd_ok        = pop & !fifo_empty;
    end

    // Storage is deliberately left unreset; reads only ever reach written entries.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= data_in;
    end

    // Pointers, occupancy, registered read data and the sticky error flags.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            data_out  <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
            if (rd_ok) begin
                rd_ptr   <= rd_ptr + AW'(1);
                data_out <= mem[rd_ptr];
            end
            count     <= (wr_ok && !rd_ok) ? count + CNT_W'(1) :
                         (rd_ok && !wr_ok) ? count - CNT_W'(1) : count;
            overflow  <= (push & !wr_ok) | (overflow & !clr_err);
            underflow <= (pop & !rd_ok) | (underflow & !clr_err);
        end
    end
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed and random checks of sync_fifo against a queue-based reference model
module tb_sync_fifo;
    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       push = 1'b0;
    logic       pop = 1'b0;
    logic [7:0] data_in = '0;
    logic       clr_err = 1'b0;
    logic [7:0] data_out;
    logic [4:0] count;
    logic       fifo_full, fifo_empty, almost_full, almost_empty, overflow, underflow;

    int tests = 0;
    int fails = 0;

    logic [7:0] q[$];
    logic [7:0] exp_do = '0;
    logic       exp_ovf = 1'b0;
    logic       exp_unf = 1'b0;

    sync_fifo dut (
        .clk(clk), .rstn(rstn), .push(push), .pop(pop), .data_in(data_in), .clr_err(clr_err),
        .data_out(data_out), .count(count), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    // Safety net so the run can never hang.
    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "[TB] %0d tests run, %0d failed", tests, fails + 1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_all(input string tag);
        int n = q.size();
        check({tag, ".count"}, 32'(count), 32'(n));
        check({tag, ".full"}, 32'(fifo_full), 32'(n == 16));
        check({tag, ".empty"}, 32'(fifo_empty), 32'(n == 0));
        check({tag, ".afull"}, 32'(almost_full), 32'(n >= 14));
        check({tag, ".aempty"}, 32'(almost_empty), 32'(n <= 2));
        check({tag, ".data_out"}, 32'(data_out), 32'(exp_do));
        check({tag, ".overflow"}, 32'(overflow), 32'(exp_ovf));
        check({tag, ".underflow"}, 32'(underflow), 32'(exp_unf));
    endtask

    task automatic model_reset();
        q.delete();
        exp_do = '0;
        exp_ovf = 1'b0;
        exp_unf = 1'b0;
    endtask

    // Drive one cycle of inputs, advance the model from the pre-edge state, then check after the edge.
    task automatic step(input string tag, input logic pu, input logic po, input logic [7:0] d, input logic ce);
        logic wr, rd;
        push = pu;
        pop = po;
        data_in = d;
        clr_err = ce;
        @(posedge clk);
        wr = pu && (q.size() < 16 || po);
        rd = po && q.size() > 0;
        if (rd) exp_do = q.pop_front();
        if (wr) q.push_back(d);
        exp_ovf = (pu && !wr) || (exp_ovf && !ce);
        exp_unf = (po && !rd) || (exp_unf && !ce);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        rstn = 1'b0;
        #2;
        model_reset();
        check_all(tag);
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    initial begin
        #3;
        model_reset();
        check_all("reset0");
        @(posedge clk);
        #1;
        rstn = 1'b1;
        for (int i = 1; i <= 16; i++) step("fill", 1'b1, 1'b0, 8'(i), 1'b0);
        step("ovf", 1'b1, 1'b0, 8'hAA, 1'b0);
        step("ovf_clr", 1'b0, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 16; i++) step("drain", 1'b0, 1'b1, 8'h00, 1'b0);
        step("empty_pushpop", 1'b1, 1'b1, 8'h55, 1'b0);
        step("pop55", 1'b0, 1'b1, 8'h00, 1'b0);
        step("unf_vs_clr", 1'b0, 1'b1, 8'h00, 1'b1);
        step("unf_clr", 1'b0, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 16; i++) step("refill", 1'b1, 1'b0, 8'(8'h80 + i), 1'b0);
        for (int i = 0; i < 20; i++) step("full_pushpop", 1'b1, 1'b1, 8'(8'h20 + i), 1'b0);
        for (int i = 0; i < 7; i++) step("to9", 1'b0, 1'b1, 8'h00, 1'b0);
        do_reset("reset_mid");
        step("push77", 1'b1, 1'b0, 8'h77, 1'b0);
        step("pop77", 1'b0, 1'b1, 8'h00, 1'b0);
        for (int i = 0; i < 600; i++) begin
            int mode = (i / 100) % 3;
            logic pu = (mode == 0) ? ($urandom_range(0, 3) != 0) : (mode == 1) ? ($urandom_range(0, 3) == 0) : 1'($urandom);
            logic po = (mode == 0) ? ($urandom_range(0, 3) == 0) : (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'($urandom);
            step("rand", pu, po, 8'($urandom), $urandom_range(0, 9) == 0);
            if (i == 350) do_reset("reset_rand");
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
